// File: rtl/pwm_multichannel_dbuf.sv
// Multi-channel PWM generator. Each channel has its own duty register, and all
// channels share one prescaler and one edge/centre counter. Duty and mode changes
// are double-buffered and only take effect at a period boundary.
module pwm_multichannel_dbuf #(
  parameter int NUM_CH     = 16,
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     en_out,
  input  logic [NUM_CH-1:0]     en_pwm,
  input  logic                  duty_wr_en,
  input  logic [CH_W-1:0]       duty_wr_ch,
  input  logic [DUTY_W-1:0]     duty_wr_data,
  input  logic [CH_W-1:0]       duty_rd_ch,
  output logic [DUTY_W-1:0]     duty_rd_data,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  mode_shadow,
  output logic [NUM_CH-1:0]     out,
  output logic                  period_start,
  output logic                  active_mode
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Highest value the counter reaches, i.e. MAX-1.
  localparam logic [DUTY_W-1:0] CNT_TOP  = DUTY_W'((1 << DUTY_W) - 2);
  localparam logic [DUTY_W-1:0] CNT_ONE  = DUTY_W'(1);
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;
  logic [DUTY_W-1:0]     counter;
  logic [DUTY_W-1:0]     counter_nxt;
  dir_t                  dir;
  dir_t                  dir_nxt;
  logic                  boundary;
  logic [DUTY_W-1:0]     shadow_duty [NUM_CH];
  logic [DUTY_W-1:0]     active_duty [NUM_CH];
  logic [NUM_CH-1:0]     pwm;
  logic                  wr_valid;
  logic                  rd_valid;

  assign wr_valid = ({1'b0, duty_wr_ch} < CH_LIMIT);
  assign rd_valid = ({1'b0, duty_rd_ch} < CH_LIMIT);
  assign duty_rd_data = rd_valid ? shadow_duty[duty_rd_ch] : '0;

  // Using >= lets a count left above a newly lowered prescale wrap on the next clock.
  assign tick = (pre_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_comb begin
    counter_nxt = counter;
    dir_nxt     = dir;
    boundary    = 1'b0;
    if (tick) begin
      if (!active_mode) begin
        if (counter >= CNT_TOP) begin
          boundary = 1'b1;
        end else begin
          counter_nxt = counter + 1'b1;
        end
      end else if (dir == DIR_UP) begin
        if (counter >= CNT_TOP) begin
          dir_nxt     = DIR_DOWN;
          counter_nxt = counter - 1'b1;
        end else begin
          counter_nxt = counter + 1'b1;
        end
      end else begin
        if (counter <= CNT_ONE) begin
          boundary = 1'b1;
        end else begin
          counter_nxt = counter - 1'b1;
        end
      end
      if (boundary) begin
        counter_nxt = '0;
        dir_nxt     = DIR_UP;
      end
    end
  end

  // Active duties sample the shadow before any same-clock write lands in it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter      <= '0;
      dir          <= DIR_UP;
      active_mode  <= 1'b0;
      period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        active_duty[i] <= '0;
      end
    end else begin
      counter      <= counter_nxt;
      dir          <= dir_nxt;
      period_start <= boundary;
      if (boundary) begin
        active_mode <= mode_shadow;
        for (int i = 0; i < NUM_CH; i++) begin
          active_duty[i] <= shadow_duty[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_duty[i] <= '0;
      end
    end else if (duty_wr_en && wr_valid) begin
      shadow_duty[duty_wr_ch] <= duty_wr_data;
    end
  end

  always_comb begin
    pwm = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm[i] = (counter < active_duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= en_out & (~en_pwm | pwm);
    end
  end

endmodule

// File: tb/tb_pwm_multichannel_dbuf.sv
// Directed testbench for pwm_multichannel_dbuf. It uses 12 channels so that
// channel indices 12..15 fit in the 4-bit select but are out of range.
module tb_pwm_multichannel_dbuf;

  localparam int NUM_CH     = 12;
  localparam int DUTY_W     = 8;
  localparam int PRESCALE_W = 8;
  localparam int CH_W       = 4;
  localparam int LIMIT      = 3000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_CH-1:0]     en_out;
  logic [NUM_CH-1:0]     en_pwm;
  logic                  duty_wr_en;
  logic [CH_W-1:0]       duty_wr_ch;
  logic [DUTY_W-1:0]     duty_wr_data;
  logic [CH_W-1:0]       duty_rd_ch;
  logic [DUTY_W-1:0]     duty_rd_data;
  logic [PRESCALE_W-1:0] prescale;
  logic                  mode_shadow;
  logic [NUM_CH-1:0]     out;
  logic                  period_start;
  logic                  active_mode;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [DUTY_W-1:0] shadow_model [NUM_CH];

  int len, highs, cnt;
  logic [NUM_CH-1:0] and_v, or_v;
  logic first_v, last_v;

  always #5 clk = ~clk;

  pwm_multichannel_dbuf #(
    .NUM_CH(NUM_CH),
    .DUTY_W(DUTY_W),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_out(en_out),
    .en_pwm(en_pwm),
    .duty_wr_en(duty_wr_en),
    .duty_wr_ch(duty_wr_ch),
    .duty_wr_data(duty_wr_data),
    .duty_rd_ch(duty_rd_ch),
    .duty_rd_data(duty_rd_data),
    .prescale(prescale),
    .mode_shadow(mode_shadow),
    .out(out),
    .period_start(period_start),
    .active_mode(active_mode)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One-clock shadow write, mirrored into the bench's own shadow model.
  task automatic applyStimulus(input int ch, input int data);
    duty_wr_en   = 1'b1;
    duty_wr_ch   = CH_W'(ch);
    duty_wr_data = DUTY_W'(data);
    @(negedge clk);
    duty_wr_en = 1'b0;
    if (ch < NUM_CH) shadow_model[ch] = DUTY_W'(data);
  endtask

  task automatic wait_period_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < LIMIT);
  endtask

  // Samples one full period, starting just after a period_start and ending on the next one.
  task automatic measure_period(input int bit_idx, output int n, output int hi,
                                output logic [NUM_CH-1:0] a_v, output logic [NUM_CH-1:0] o_v,
                                output logic f_v, output logic l_v);
    n = 0;
    hi = 0;
    a_v = '1;
    o_v = '0;
    f_v = 1'b0;
    l_v = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (out[bit_idx]) hi++;
      if (n == 1) f_v = out[bit_idx];
      l_v = out[bit_idx];
      a_v &= out;
      o_v |= out;
    end while (!period_start && n < LIMIT);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    en_out       = '0;
    en_pwm       = '0;
    duty_wr_en   = 1'b0;
    duty_wr_ch   = '0;
    duty_wr_data = '0;
    duty_rd_ch   = '0;
    prescale     = '0;
    mode_shadow  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) shadow_model[i] = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset_out", 32'(out), 32'h0);
    checkOutput("reset_period_start", 32'(period_start), 32'h0);
    checkOutput("reset_active_mode", 32'(active_mode), 32'h0);
    checkOutput("reset_readback", 32'(duty_rd_data), 32'h0);

    // Test 1/2: edge mode, prescale 0, channel mix
    rst_n  = 1'b1;
    en_out = 12'b0000_0010_1111;
    en_pwm = 12'b1111_1111_1011;
    applyStimulus(3, 128);
    applyStimulus(0, 0);
    applyStimulus(1, 255);
    applyStimulus(4, 200);
    applyStimulus(5, 10);
    @(negedge clk);
    checkOutput("first_period_out", 32'(out), 32'h004);
    duty_rd_ch = 4'd3;
    #1;
    checkOutput("readback_ch3", 32'(duty_rd_data), 32'd128);
    wait_period_start(cnt);
    checkOutput("first_boundary_delay", 32'(cnt), 32'd249);

    for (int p = 0; p < 3; p++) begin
      measure_period(3, len, highs, and_v, or_v, first_v, last_v);
      checkOutput($sformatf("edge_len_p%0d", p), 32'(len), 32'd255);
      checkOutput($sformatf("edge_high_ch3_p%0d", p), 32'(highs), 32'd128);
      checkOutput($sformatf("edge_first_ch3_p%0d", p), 32'(first_v), 32'd1);
      checkOutput($sformatf("edge_last_ch3_p%0d", p), 32'(last_v), 32'd0);
      checkOutput($sformatf("duty0_ch0_p%0d", p), 32'(or_v[0]), 32'd0);
      checkOutput($sformatf("duty255_ch1_p%0d", p), 32'(and_v[1]), 32'd1);
      checkOutput($sformatf("static_ch2_p%0d", p), 32'(and_v[2]), 32'd1);
      checkOutput($sformatf("disabled_ch4_p%0d", p), 32'(or_v[4]), 32'd0);
    end

    // Test 3: prescaler of 3 stretches every tick to 4 clocks
    prescale = 8'd3;
    wait_period_start(cnt);
    checkOutput("ps_prescale_seen", 32'(cnt < LIMIT), 32'd1);
    measure_period(5, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("prescale_len", 32'(len), 32'd1020);
    checkOutput("prescale_high_ch5", 32'(highs), 32'd40);
    measure_period(5, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("prescale_spacing", 32'(len), 32'd1020);

    // Test 4: mid-period write and write on the boundary clock
    prescale = 8'd0;
    wait_period_start(cnt);
    checkOutput("ps_prescale0_seen", 32'(cnt < LIMIT), 32'd1);
    repeat (50) @(negedge clk);
    applyStimulus(3, 64);
    measure_period(3, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("midwrite_rest_len", 32'(len), 32'd204);
    checkOutput("midwrite_rest_high", 32'(highs), 32'd77);
    measure_period(3, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("midwrite_new_high", 32'(highs), 32'd64);
    repeat (254) @(negedge clk);
    applyStimulus(3, 32);
    checkOutput("bndwrite_on_boundary", 32'(period_start), 32'd1);
    measure_period(3, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("bndwrite_old_high", 32'(highs), 32'd64);
    measure_period(3, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("bndwrite_new_high", 32'(highs), 32'd32);

    // Test 5: centre-aligned mode
    applyStimulus(3, 100);
    mode_shadow = 1'b1;
    @(negedge clk);
    checkOutput("mode_not_yet_applied", 32'(active_mode), 32'd0);
    wait_period_start(cnt);
    checkOutput("mode_applied", 32'(active_mode), 32'd1);
    measure_period(3, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("centre_len", 32'(len), 32'd508);
    checkOutput("centre_high_ch3", 32'(highs), 32'd199);
    checkOutput("centre_duty255_ch1", 32'(and_v[1]), 32'd1);
    measure_period(1, len, highs, and_v, or_v, first_v, last_v);
    checkOutput("centre_high_ch1", 32'(highs), 32'd508);

    // Test 6: out-of-range write, readback, then reset mid-period
    applyStimulus(12, 77);
    for (int ch = 0; ch <= NUM_CH; ch++) begin
      duty_rd_ch = CH_W'(ch);
      #1;
      checkOutput($sformatf("readback_ch%0d", ch), 32'(duty_rd_data),
                  (ch < NUM_CH) ? 32'(shadow_model[ch]) : 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_out", 32'(out), 32'h0);
    checkOutput("midreset_period_start", 32'(period_start), 32'd0);
    checkOutput("midreset_active_mode", 32'(active_mode), 32'd0);
    duty_rd_ch = 4'd3;
    #1;
    checkOutput("midreset_readback", 32'(duty_rd_data), 32'd0);
    for (int i = 0; i < NUM_CH; i++) shadow_model[i] = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_reset_out", 32'(out), 32'h004);
    wait_period_start(cnt);
    checkOutput("after_reset_restart", 32'(cnt), 32'd254);
    checkOutput("after_reset_mode", 32'(active_mode), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
